// File: rtl/dac7611_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | dac7611_pkg : shared constants, FSM encodings, grant search        |
// | Revision    : 1.0                                                  |
// +-------------------------------------------------------------------+
package dac7611_pkg;

    localparam int DAC_BITS = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_GAP   = 3'd4,
        ST_CLEAR = 3'd5
    } arb_state_t;

    typedef enum logic [1:0] {
        SH_IDLE  = 2'd0,
        SH_LOW   = 2'd1,
        SH_HIGH  = 2'd2,
        SH_LATCH = 2'd3
    } shift_state_t;

    // Nearest valid requester after ptr, wrapping; scanned far-to-near so
    // the last hit is the winner. ptr = num_req-1 gives lowest-index priority.
    function automatic logic [2:0] grant_search(input logic [7:0] valid,
                                                input logic [2:0] ptr,
                                                input int         num_req);
        logic [2:0] win;
        int         idx;
        win = ptr;
        for (int k = 8; k >= 1; k--) begin
            if (k <= num_req) begin
                idx = (int'(ptr) + k) % num_req;
                if (valid[idx]) win = 3'(idx);
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac7611_frame_shifter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | dac7611_frame_shifter : 12-bit MSB-first shift plus LD pulse       |
// | Revision              : 1.0                                        |
// +-------------------------------------------------------------------+
module dac7611_frame_shifter
    import dac7611_pkg::*;
#(
    parameter int SCLK_HALF = 2,
    parameter int LD_CYC    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DAC_BITS-1:0] data,
    output logic                CLK,
    output logic                SDI,
    output logic                LD,
    output logic                done
);

    localparam logic [7:0] C_HALF = 8'(SCLK_HALF - 1);
    localparam logic [7:0] C_LD   = 8'(LD_CYC - 1);

    shift_state_t        state;
    logic [7:0]          cnt;
    logic [3:0]          bit_idx;
    logic [DAC_BITS-1:0] shreg;

    // Combinational so the arbiter leaves LATCH on the same edge LD rises.
    assign done = (state == SH_LATCH) && (cnt == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SH_IDLE;
            cnt     <= 8'd0;
            bit_idx <= 4'd0;
            shreg   <= '0;
            CLK     <= 1'b1;
            SDI     <= 1'b0;
            LD      <= 1'b1;
        end else begin
            case (state)
                SH_IDLE: begin
                    if (start) begin
                        state   <= SH_LOW;
                        shreg   <= data;
                        bit_idx <= 4'(DAC_BITS - 1);
                        SDI     <= data[DAC_BITS-1];
                        CLK     <= 1'b0;
                        cnt     <= C_HALF;
                    end
                end
                SH_LOW: begin
                    if (cnt == 8'd0) begin
                        CLK   <= 1'b1;
                        state <= SH_HIGH;
                        cnt   <= C_HALF;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                SH_HIGH: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (bit_idx == 4'd0) begin
                        state <= SH_LATCH;
                        SDI   <= 1'b0;
                        LD    <= 1'b0;
                        cnt   <= C_LD;
                    end else begin
                        bit_idx <= bit_idx - 4'd1;
                        SDI     <= shreg[bit_idx-4'd1];
                        CLK     <= 1'b0;
                        state   <= SH_LOW;
                        cnt     <= C_HALF;
                    end
                end
                SH_LATCH: begin
                    if (cnt == 8'd0) begin
                        LD    <= 1'b1;
                        state <= SH_IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= SH_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dac7611_write_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | dac7611_write_arbiter : round-robin writer/clear sequencer for one  |
// | DAC7611; DAC_FIXED_PRIO_EN selects lowest-index priority. Rev 1.0   |
// +-------------------------------------------------------------------+
module dac7611_write_arbiter
    import dac7611_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int SCLK_HALF = 2,
    parameter int LD_CYC    = 2,
    parameter int CLR_CYC   = 2,
    parameter int GAP_CYC   = 2
) (
    input  logic                        clk_50M,
    input  logic                        locked,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [DAC_BITS*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        clr_req,
    output logic                        busy,
    output logic                        CLK_3,
    output logic                        SDI_4,
    output logic                        LD_5,
    output logic                        CLR_6
);

    localparam logic [2:0] C_LAST       = 3'(NUM_REQ - 1);
    localparam logic [7:0] C_CLR        = 8'(CLR_CYC - 1);
    localparam logic [7:0] C_GAP        = 8'(GAP_CYC - 1);
    localparam arb_state_t C_AFTER      = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
    localparam logic       C_AFTER_BUSY = (GAP_CYC != 0);

    arb_state_t          state;
    logic [7:0]          cnt;
    logic                clr_pend;
    logic                start;
    logic [DAC_BITS-1:0] data_q;
    logic [2:0]          ptr;
    logic [2:0]          win;
    logic [NUM_REQ-1:0]  win_onehot;
    logic                ld;
    logic                done;

`ifdef DAC_FIXED_PRIO_EN
    assign ptr = C_LAST;
`endif

    assign win  = grant_search(8'(req_valid), ptr, NUM_REQ);
    assign LD_5 = ld;

    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_onehot[i] = (win == 3'(i));
        end
    end

    always_ff @(posedge clk_50M or negedge locked) begin
        if (!locked) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            clr_pend  <= 1'b0;
            start     <= 1'b0;
            data_q    <= '0;
            req_ready <= '0;
            busy      <= 1'b0;
            CLR_6     <= 1'b1;
`ifndef DAC_FIXED_PRIO_EN
            ptr       <= C_LAST;
`endif
        end else begin
            start     <= 1'b0;
            req_ready <= '0;
            case (state)
                ST_IDLE: begin
                    // Pending flag drops on entry so a clr_req seen during
                    // CLEAR re-arms it for one more clear.
                    if (clr_pend) begin
                        state    <= ST_CLEAR;
                        clr_pend <= 1'b0;
                        CLR_6    <= 1'b0;
                        cnt      <= C_CLR;
                        busy     <= 1'b1;
                    end else if (|req_valid) begin
                        state     <= ST_GRANT;
                        req_ready <= win_onehot;
                        data_q    <= req_data[int'(win)*DAC_BITS +: DAC_BITS];
                        start     <= 1'b1;
                        busy      <= 1'b1;
`ifndef DAC_FIXED_PRIO_EN
                        ptr       <= win;
`endif
                    end
                end
                ST_GRANT: state <= ST_SHIFT;
                ST_SHIFT: begin
                    if (done) begin
                        state <= C_AFTER;
                        busy  <= C_AFTER_BUSY;
                        cnt   <= C_GAP;
                    end else if (!ld) begin
                        state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (done) begin
                        state <= C_AFTER;
                        busy  <= C_AFTER_BUSY;
                        cnt   <= C_GAP;
                    end
                end
                ST_CLEAR: begin
                    if (cnt == 8'd0) begin
                        CLR_6 <= 1'b1;
                        state <= C_AFTER;
                        busy  <= C_AFTER_BUSY;
                        cnt   <= C_GAP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == 8'd0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (clr_req) clr_pend <= 1'b1;
        end
    end

    dac7611_frame_shifter #(
        .SCLK_HALF (SCLK_HALF),
        .LD_CYC    (LD_CYC)
    ) u_shifter (
        .clk   (clk_50M),
        .rst_n (locked),
        .start (start),
        .data  (data_q),
        .CLK   (CLK_3),
        .SDI   (SDI_4),
        .LD    (ld),
        .done  (done)
    );

endmodule
`default_nettype wire
